// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs uart_receiver bytes into BYTES_PER_WORD-byte words
// with an inter-byte timeout, a valid/ready output and overflow accounting.
`timescale 1ns/1ps
module uart_word_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd_flag,
  input  logic [7:0]                  rxd_data,
  input  logic                        word_ready,
  input  logic                        ovf_clr,
  output logic [BYTES_PER_WORD*8-1:0] word_data,
  output logic                        word_valid,
  output logic [2:0]                  byte_cnt,
  output logic                        timeout_pulse,
  output logic [7:0]                  ovf_cnt
);

  localparam int         WW        = BYTES_PER_WORD * 8;
  localparam logic [2:0] LAST_SLOT = 3'(BYTES_PER_WORD - 1);

  logic          flag_d;
  logic          accept;
  logic          last_byte;
  logic          slot_free;
  logic          load_word;
  logic          overflow;
  logic          timeout_hit;
  logic [2:0]    slot;
  logic [WW-1:0] asm_q;
  logic [WW-1:0] full_word;

  // A held rxd_flag counts once: only its rising edge accepts a byte.
  assign accept    = rxd_flag & ~flag_d;
  assign last_byte = (byte_cnt == LAST_SLOT);
  assign slot_free = ~word_valid | word_ready;
  assign load_word = accept & last_byte & slot_free;
  assign overflow  = accept & last_byte & ~slot_free;
  assign slot      = (MSB_FIRST != 0) ? (LAST_SLOT - byte_cnt) : byte_cnt;

  always_comb begin
    full_word = asm_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (slot == 3'(i)) full_word[8*i +: 8] = rxd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_d <= 1'b0;
    else        flag_d <= rxd_flag;
  end

  // Assembly register is cleared on completion and on timeout so no stale byte leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 3'd0;
      asm_q    <= '0;
    end else if (accept) begin
      if (last_byte) begin
        byte_cnt <= 3'd0;
        asm_q    <= '0;
      end else begin
        byte_cnt <= byte_cnt + 3'd1;
        asm_q    <= full_word;
      end
    end else if (timeout_hit) begin
      byte_cnt <= 3'd0;
      asm_q    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
    end else if (load_word) begin
      word_data  <= full_word;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Clear wins over a concurrent overflow except that the overflow itself is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'd0;
    end else if (ovf_clr) begin
      ovf_cnt <= {7'd0, overflow};
    end else if (overflow && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] idle_cnt;

      // An accepted byte on the expiry cycle beats the timeout.
      assign timeout_hit = ~accept & (byte_cnt != 3'd0) & (idle_cnt == TMO_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          idle_cnt      <= '0;
          timeout_pulse <= 1'b0;
        end else begin
          timeout_pulse <= timeout_hit;
          if (accept || (byte_cnt == 3'd0) || timeout_hit) idle_cnt <= '0;
          else                                             idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign timeout_hit   = 1'b0;
      assign timeout_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - bench for uart_word_packer: four parameterisations share one
// byte stream and are checked every cycle against a queue-level model plus directed literals.
`timescale 1ns/1ps
module tb_uart_word_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_flag = 1'b0;
  logic [7:0] rxd_data = 8'd0;
  logic       word_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  always #5 clk = ~clk;

  logic [15:0]     wd_a;
  logic [31:0]     wd_b;
  logic [15:0]     wd_c;
  logic [7:0]      wd_d;
  logic [3:0]      wv;
  logic [3:0]      tp;
  logic [3:0][2:0] bc;
  logic [3:0][7:0] ov;
  logic [63:0]     d_wd [4];

  always_comb begin
    d_wd[0] = 64'(wd_a);
    d_wd[1] = 64'(wd_b);
    d_wd[2] = 64'(wd_c);
    d_wd[3] = 64'(wd_d);
  end

  uart_word_packer #(.BYTES_PER_WORD(2), .MSB_FIRST(0), .TIMEOUT_CYCLES(20), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .rxd_flag(rxd_flag), .rxd_data(rxd_data), .word_ready(word_ready),
    .ovf_clr(ovf_clr), .word_data(wd_a), .word_valid(wv[0]), .byte_cnt(bc[0]),
    .timeout_pulse(tp[0]), .ovf_cnt(ov[0]));

  uart_word_packer #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(20), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .rxd_flag(rxd_flag), .rxd_data(rxd_data), .word_ready(word_ready),
    .ovf_clr(ovf_clr), .word_data(wd_b), .word_valid(wv[1]), .byte_cnt(bc[1]),
    .timeout_pulse(tp[1]), .ovf_cnt(ov[1]));

  uart_word_packer dut_c (
    .clk(clk), .rst_n(rst_n), .rxd_flag(rxd_flag), .rxd_data(rxd_data), .word_ready(word_ready),
    .ovf_clr(ovf_clr), .word_data(wd_c), .word_valid(wv[2]), .byte_cnt(bc[2]),
    .timeout_pulse(tp[2]), .ovf_cnt(ov[2]));

  uart_word_packer #(.BYTES_PER_WORD(1), .MSB_FIRST(0), .TIMEOUT_CYCLES(0), .CNT_W(16)) dut_d (
    .clk(clk), .rst_n(rst_n), .rxd_flag(rxd_flag), .rxd_data(rxd_data), .word_ready(word_ready),
    .ovf_clr(ovf_clr), .word_data(wd_d), .word_valid(wv[3]), .byte_cnt(bc[3]),
    .timeout_pulse(tp[3]), .ovf_cnt(ov[3]));

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Model: a list of pending bytes per instance, an idle-cycle count, and one output slot.
  int          bpw [4] = '{2, 4, 2, 1};
  int          msb [4] = '{0, 1, 0, 0};
  int          tmo [4] = '{20, 20, 50000, 0};
  int          m_cnt  [4];
  int          m_idle [4];
  int          m_ovf  [4];
  logic [7:0]  m_bytes [4][8];
  logic        m_valid [4];
  logic        m_pulse [4];
  logic [63:0] m_data  [4];
  logic        m_prev;

  always @(posedge clk or negedge rst_n) begin : model
    logic        acc;
    logic        free;
    logic        ovfl;
    logic [63:0] w;
    int          pos;
    if (!rst_n) begin
      m_prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_idle[i] = 0; m_ovf[i] = 0;
        m_valid[i] = 1'b0; m_pulse[i] = 1'b0; m_data[i] = '0;
      end
    end else begin
      acc    = rxd_flag && !m_prev;
      m_prev = rxd_flag;
      for (int i = 0; i < 4; i++) begin
        free       = !m_valid[i] || word_ready;
        ovfl       = 1'b0;
        m_pulse[i] = 1'b0;
        if (m_valid[i] && word_ready) m_valid[i] = 1'b0;
        if (acc) begin
          m_bytes[i][m_cnt[i]] = rxd_data;
          m_cnt[i]++;
          m_idle[i] = 0;
          if (m_cnt[i] == bpw[i]) begin
            w = '0;
            for (int k = 0; k < bpw[i]; k++) begin
              pos = (msb[i] != 0) ? (bpw[i] - 1 - k) : k;
              w   = w | (64'(m_bytes[i][k]) << (8 * pos));
            end
            m_cnt[i] = 0;
            if (free) begin
              m_data[i]  = w;
              m_valid[i] = 1'b1;
            end else begin
              ovfl = 1'b1;
            end
          end
        end else if (tmo[i] != 0 && m_cnt[i] != 0) begin
          m_idle[i]++;
          if (m_idle[i] == tmo[i]) begin
            m_cnt[i]   = 0;
            m_idle[i]  = 0;
            m_pulse[i] = 1'b1;
          end
        end
        if (ovf_clr)                      m_ovf[i] = ovfl ? 1 : 0;
        else if (ovfl && m_ovf[i] < 255)  m_ovf[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk("word_valid",    i, 64'(wv[i]),    64'(m_valid[i]));
        chk("word_data",     i, d_wd[i],       m_data[i]);
        chk("byte_cnt",      i, 64'(bc[i]),    64'(m_cnt[i]));
        chk("timeout_pulse", i, 64'(tp[i]),    64'(m_pulse[i]));
        chk("ovf_cnt",       i, 64'(ov[i]),    64'(m_ovf[i]));
      end
    end
  end

  task automatic send(input logic [7:0] d, input int hold, input bit set_rdy);
    @(posedge clk); #1;
    rxd_flag = 1'b1;
    rxd_data = d;
    if (set_rdy) word_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rxd_flag = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [7:0] t2b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  int         hold_left;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 64'(wv[i]), 64'd0);
      chk("rst_data",  i, d_wd[i],    64'd0);
      chk("rst_cnt",   i, 64'(bc[i]), 64'd0);
      chk("rst_ovf",   i, 64'(ov[i]), 64'd0);
    end

    // default packing, long gap between bytes
    word_ready = 1'b1;
    send(8'h34, 1, 1'b0);
    chk("t1_cnt", 2, 64'(bc[2]), 64'd1);
    repeat (100) @(posedge clk);
    send(8'h12, 1, 1'b0);
    chk("t1_valid", 2, 64'(wv[2]), 64'd1);
    chk("t1_data",  2, d_wd[2],    64'h1234);
    @(posedge clk); #1;
    chk("t1_valid_drop", 2, 64'(wv[2]), 64'd0);

    // 4-byte MSB-first, flag held 3 cycles
    reset_dut();
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(t2b[k], 3, 1'b0);
      chk("t2_cnt", 1, 64'(bc[1]), 64'((k + 1) % 4));
    end
    chk("t2_valid", 1, 64'(wv[1]), 64'd1);
    chk("t2_data",  1, d_wd[1],    64'hDEADBEEF);

    // timeout discards a partial word; a byte on the expiry cycle wins
    reset_dut();
    word_ready = 1'b1;
    send(8'hAA, 1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      chk("t3_pulse", 0, 64'(tp[0]), 64'(k == 20));
    end
    chk("t3_cnt", 0, 64'(bc[0]), 64'd0);
    send(8'h01, 1, 1'b0);
    send(8'h02, 1, 1'b0);
    chk("t3_valid", 0, 64'(wv[0]), 64'd1);
    chk("t3_data",  0, d_wd[0],    64'h0201);
    send(8'h33, 1, 1'b0);
    repeat (18) @(posedge clk);
    send(8'h44, 1, 1'b0);
    chk("t3_edge_pulse", 0, 64'(tp[0]), 64'd0);
    chk("t3_edge_valid", 0, 64'(wv[0]), 64'd1);
    chk("t3_edge_data",  0, d_wd[0],    64'h4433);

    // backpressure and overflow accounting
    reset_dut();
    word_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(8'(8'h11 * (k + 1)), 1, 1'b0);
    chk("t4_valid", 0, 64'(wv[0]), 64'd1);
    chk("t4_data",  0, d_wd[0],    64'h2211);
    chk("t4_ovf",   0, 64'(ov[0]), 64'd2);
    chk("t4_data_b", 1, d_wd[1],   64'h11223344);
    @(posedge clk); #1 word_ready = 1'b1;
    @(posedge clk); #1 word_ready = 1'b0;
    chk("t4_drop", 0, 64'(wv[0]), 64'd0);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    chk("t4_clr", 0, 64'(ov[0]), 64'd0);

    // transfer and new word in the same cycle
    send(8'hA1, 1, 1'b0);
    send(8'hA2, 1, 1'b0);
    chk("t5_first", 0, d_wd[0], 64'hA2A1);
    send(8'hB1, 1, 1'b0);
    send(8'hB2, 1, 1'b1);
    chk("t5_valid", 0, 64'(wv[0]), 64'd1);
    chk("t5_data",  0, d_wd[0],    64'hB2B1);
    chk("t5_ovf",   0, 64'(ov[0]), 64'd0);

    // asynchronous reset mid-word
    send(8'hC3, 1, 1'b0);
    chk("t6_pre_cnt", 0, 64'(bc[0]), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_rst_cnt",   i, 64'(bc[i]), 64'd0);
      chk("t6_rst_valid", i, 64'(wv[i]), 64'd0);
      chk("t6_rst_data",  i, d_wd[i],    64'd0);
    end
    #2 rst_n = 1'b1;
    send(8'h56, 1, 1'b0);
    send(8'h78, 1, 1'b0);
    chk("t6_valid", 0, 64'(wv[0]), 64'd1);
    chk("t6_data",  0, d_wd[0],    64'h7856);

    // randomized traffic, ready and clears
    hold_left = 0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      word_ready = ($urandom_range(0, 2) != 0);
      ovf_clr    = ($urandom_range(0, 63) == 0);
      if (rxd_flag) begin
        if (hold_left > 1) hold_left--;
        else begin
          rxd_flag  = 1'b0;
          hold_left = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rxd_flag  = 1'b1;
        rxd_data  = 8'($urandom);
        hold_left = $urandom_range(1, 3);
      end
    end
    @(posedge clk); #1;
    rxd_flag = 1'b0;
    ovf_clr  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
